wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single regfile write port between the in-order pipeline WB stage and the multi-cycle MDU (mul/div).
//  MDU results queue in a small FIFO; WB has priority, bounded by a starvation counter that stalls WB.
//  Sits between the WB-stage write-data mux and the regfile; outputs are registered.
//  Also exports a pending-destination mask for hazard detection.
// PARAMETERS
//  DATA_W      64  width of write data
//  FIFO_DEPTH  2   MDU result queue entries (power of 2, >=2)
//  STARVE_MAX  4   consecutive WB wins while FIFO non-empty before WB is stalled
// PORTS
//  clk        in   1       clock
//  reset      in   1       async, active-high
//  wb_valid   in   1       WB stage has a regfile write this cycle
//  wb_rd      in   5       WB destination
//  wb_data    in   DATA_W  WB write data (from WB mux)
//  wb_stall   out  1       comb; WB write not taken, pipeline must hold
//  mdu_valid  in   1       MDU result offered
//  mdu_rd     in   5       MDU destination
//  mdu_data   in   DATA_W  MDU result
//  mdu_ready  out  1       comb; = FIFO not full
//  flush      in   1       discard all queued MDU results
//  rf_wen     out  1       reg; regfile write enable
//  rf_wa      out  5       reg; regfile write address
//  rf_wd      out  DATA_W  reg; regfile write data
//  pend_mask  out  32      comb; bit r set iff a live FIFO entry targets r (r!=0)
// BEHAVIOUR
//  - Reset (async): FIFO empty, starve_cnt=0, rf_wen=0, rf_wa=0, rf_wd=0; hence mdu_ready=1, pend_mask=0, wb_stall=0.
//  - Per-cycle grant, priority order:
//    1. starve = (starve_cnt==STARVE_MAX) && !empty && !flush -> grant FIFO head; wb_stall=wb_valid.
//    2. else wb_valid -> grant WB.
//    3. else !empty && !flush -> grant FIFO head.
//  - Granted request reaches rf_wen/rf_wa/rf_wd at next edge (1-cycle latency).
//    rf_wen=0 if granted rd==0, granted FIFO entry is dead, or no grant.
//  - FIFO head pops when granted, dead or live (dead pop = no write).
//  - Enqueue: mdu_valid && mdu_ready && !flush. Full FIFO gives mdu_ready=0: no same-cycle push/pop when full.
//    A push into an empty FIFO is granted no earlier than the next cycle.
//  - Kill (WAW): WB is younger than every queued/incoming MDU result.
//    On a WB grant with rd!=0:
//    - every live entry with matching rd becomes dead at the edge;
//    - a same-cycle enqueue with matching rd is written dead.
//  - starve_cnt:
//    - +1 (saturating at STARVE_MAX) on a WB grant while FIFO non-empty;
//    - cleared on a FIFO grant, when empty, or on flush.
//  - flush: FIFO emptied and starve_cnt cleared at edge; FIFO grant suppressed that cycle.
//    A WB grant in the flush cycle is still written.
//  - pend_mask: OR of onehot(rd) over live entries. Dead entries and rd==0 are excluded.
//  - Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  - Reset mid-operation: all state cleared immediately. A write in flight is dropped (rf_wen=0 asynchronously).
// STRUCTURE
//  - Shared package (common):
//    - typedef wb_req_t {logic [4:0] rd; logic [DATA_W-1:0] data;}
//    - enum grant_t {GNT_NONE, GNT_WB, GNT_MDU}
//    - REG_ADDR_W=5
//  - Sub-module wb_result_fifo: DEPTH entries of wb_req_t plus live bit.
//    Has a kill_en/kill_rd port and exposes head plus per-entry rd/live for pend_mask.
//  - Top: grant logic, starve counter, output registers.
// TESTING
//  1. WB only: wb_valid, rd=5, data=0x11 at cycle 0 -> cycle 1: rf_wen=1, rf_wa=5, rf_wd=0x11; wb_stall=0.
//  2. MDU only: push rd=7, data=0xAA at c0 -> pend_mask[7]=1 at c1, granted c1 -> rf write rd=7, 0xAA at c2; pend_mask=0 at c2.
//  3. Starvation: FIFO holds rd=9; wb_valid each cycle rd=1..4 -> 4 WB writes.
//     5th cycle: wb_stall=1 and rf writes rd=9. Next cycle: the stalled WB write proceeds.
//  4. Kill: FIFO holds rd=3/0xA; WB grant rd=3/0xB -> pend_mask[3]=0 next cycle.
//     Later pop gives rf_wen=0; last write to x3 is 0xB.
//  5. rd=0: WB rd=0 and MDU rd=0 results -> rf_wen never 1; pend_mask stays 0; FIFO still drains.
//  6. Flush/reset:
//     - full FIFO (2 entries) plus flush -> next cycle mdu_ready=1, pend_mask=0, no stale writes.
//     - reset asserted mid-write (between edges) -> rf_wen=0 immediately.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and helpers for the regfile write-port arbiter.
// The grant encoding and the request bundle are shared by the FIFO and the top.
package wb_port_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int WB_DATA_W  = 64;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0]  data;
   } wb_req_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_WB   = 2'd1,
      GNT_MDU  = 2'd2
   } grant_t;

   function automatic logic [31:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
      logic [31:0] one;
      one = 32'd1;
      return one << rd;
   endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small queue of MDU results waiting for the regfile write port.
// Each entry carries a live bit so that a younger WB write can kill it in place.
module wb_result_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  push_dead,
   input  logic [REG_ADDR_W-1:0] push_rd,
   input  logic [DATA_W-1:0]     push_data,
   input  logic                  pop,
   input  logic                  flush,
   input  logic                  kill_en,
   input  logic [REG_ADDR_W-1:0] kill_rd,
   output logic                  empty,
   output logic                  full,
   output logic [REG_ADDR_W-1:0] head_rd,
   output logic [DATA_W-1:0]     head_data,
   output logic                  head_live,
   output logic [REG_ADDR_W-1:0] ent_rd [DEPTH],
   output logic [DEPTH-1:0]      ent_live
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
   logic [DATA_W-1:0]     data_q [DEPTH];
   logic [DEPTH-1:0]      live_q;
   logic [PTR_W-1:0]      wptr;
   logic [PTR_W-1:0]      rptr;
   logic [CNT_W-1:0]      count;

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign head_rd   = rd_q[rptr];
   assign head_data = data_q[rptr];
   assign head_live = live_q[rptr];
   assign ent_rd    = rd_q;
   assign ent_live  = live_q;

   // Live bits are cleared on pop, so a set live bit always means an occupied slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
         live_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else if (flush) begin
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
         live_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && live_q[i] && (rd_q[i] == kill_rd)) begin
               live_q[i] <= 1'b0;
            end
         end
         if (pop) begin
            live_q[rptr] <= 1'b0;
            rptr         <= rptr + PTR_W'(1);
         end
         if (push) begin
            rd_q[wptr]   <= push_rd;
            data_q[wptr] <= push_data;
            live_q[wptr] <= ~push_dead;
            wptr         <= wptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the WB stage and queued MDU results.
// WB normally wins; a starvation counter eventually stalls WB to drain the queue.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0]     wb_data,
   output logic                  wb_stall,
   input  logic                  mdu_valid,
   input  logic [REG_ADDR_W-1:0] mdu_rd,
   input  logic [DATA_W-1:0]     mdu_data,
   output logic                  mdu_ready,
   input  logic                  flush,
   output logic                  rf_wen,
   output logic [REG_ADDR_W-1:0] rf_wa,
   output logic [DATA_W-1:0]     rf_wd,
   output logic [31:0]           pend_mask
);

   localparam int STARVE_W = $clog2(STARVE_MAX + 1);

   logic                  fifo_empty;
   logic                  fifo_full;
   logic [REG_ADDR_W-1:0] head_rd;
   logic [DATA_W-1:0]     head_data;
   logic                  head_live;
   logic [REG_ADDR_W-1:0] ent_rd [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] ent_live;

   logic [STARVE_W-1:0]   starve_cnt;
   logic                  starve;
   grant_t                grant;
   logic                  push;
   logic                  pop;
   logic                  kill_en;
   logic                  push_dead;

   assign mdu_ready = ~fifo_full;
   assign starve    = (starve_cnt == STARVE_W'(STARVE_MAX)) && !fifo_empty && !flush;
   assign wb_stall  = starve && wb_valid;
   assign push      = mdu_valid && mdu_ready && !flush;
   assign pop       = (grant == GNT_MDU);
   assign kill_en   = (grant == GNT_WB) && (wb_rd != '0);
   // WB is younger than any MDU result, so a same-cycle enqueue to its rd is already stale.
   assign push_dead = kill_en && (mdu_rd == wb_rd);

   always_comb begin
      grant = GNT_NONE;
      if (starve) begin
         grant = GNT_MDU;
      end else if (wb_valid) begin
         grant = GNT_WB;
      end else if (!fifo_empty && !flush) begin
         grant = GNT_MDU;
      end
   end

   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (ent_live[i] && (ent_rd[i] != '0)) begin
            pend_mask = pend_mask | rd_onehot(ent_rd[i]);
         end
      end
   end

   wb_result_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_dead (push_dead),
      .push_rd   (mdu_rd),
      .push_data (mdu_data),
      .pop       (pop),
      .flush     (flush),
      .kill_en   (kill_en),
      .kill_rd   (wb_rd),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .head_rd   (head_rd),
      .head_data (head_data),
      .head_live (head_live),
      .ent_rd    (ent_rd),
      .ent_live  (ent_live)
   );

   // Counts consecutive WB wins over a waiting MDU result; any FIFO grant resets it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (flush || fifo_empty || (grant == GNT_MDU)) begin
         starve_cnt <= '0;
      end else if ((grant == GNT_WB) && (starve_cnt != STARVE_W'(STARVE_MAX))) begin
         starve_cnt <= starve_cnt + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_wen <= 1'b0;
         rf_wa  <= '0;
         rf_wd  <= '0;
      end else begin
         rf_wen <= 1'b0;
         if ((grant == GNT_WB) && (wb_rd != '0)) begin
            rf_wen <= 1'b1;
            rf_wa  <= wb_rd;
            rf_wd  <= wb_data;
         end else if ((grant == GNT_MDU) && head_live && (head_rd != '0)) begin
            rf_wen <= 1'b1;
            rf_wa  <= head_rd;
            rf_wd  <= head_data;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_wb_port_arbiter;
   import wb_port_arbiter_pkg::*;

   localparam int DATA_W = 64;

   logic              clk;
   logic              reset;
   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic              wb_stall;
   logic              mdu_valid;
   logic [4:0]        mdu_rd;
   logic [DATA_W-1:0] mdu_data;
   logic              mdu_ready;
   logic              flush;
   logic              rf_wen;
   logic [4:0]        rf_wa;
   logic [DATA_W-1:0] rf_wd;
   logic [31:0]       pend_mask;

   int checks = 0;
   int errors = 0;

   wb_port_arbiter #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (2),
      .STARVE_MAX (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .wb_stall  (wb_stall),
      .mdu_valid (mdu_valid),
      .mdu_rd    (mdu_rd),
      .mdu_data  (mdu_data),
      .mdu_ready (mdu_ready),
      .flush     (flush),
      .rf_wen    (rf_wen),
      .rf_wa     (rf_wa),
      .rf_wd     (rf_wd),
      .pend_mask (pend_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic wv, input logic [4:0] wrd, input logic [63:0] wd,
                                input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                                input logic fl);
      wb_valid  = wv;
      wb_rd     = wrd;
      wb_data   = wd;
      mdu_valid = mv;
      mdu_rd    = mrd;
      mdu_data  = md;
      flush     = fl;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkWrite(input string tag, input logic [4:0] wa, input logic [63:0] wd);
      checkOutput({tag, "_wen"}, 64'(rf_wen), 64'd1);
      checkOutput({tag, "_wa"}, 64'(rf_wa), 64'(wa));
      checkOutput({tag, "_wd"}, rf_wd, wd);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      #1;
      checkOutput("rst_wen", 64'(rf_wen), 64'd0);
      checkOutput("rst_wa", 64'(rf_wa), 64'd0);
      checkOutput("rst_wd", rf_wd, 64'd0);
      checkOutput("rst_ready", 64'(mdu_ready), 64'd1);
      checkOutput("rst_pend", 64'(pend_mask), 64'd0);
      checkOutput("rst_stall", 64'(wb_stall), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      tick();

      $display("[TB] WB-only write");
      applyStimulus(1'b1, 5'd5, 64'h11, 1'b0, 5'd0, 64'h0, 1'b0);
      checkOutput("wb_stall0", 64'(wb_stall), 64'd0);
      tick();
      checkWrite("wb5", 5'd5, 64'h11);
      idle();
      tick();
      checkOutput("wb_idle_wen", 64'(rf_wen), 64'd0);

      $display("[TB] MDU-only write");
      applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'hAA, 1'b0);
      checkOutput("mdu_ready_empty", 64'(mdu_ready), 64'd1);
      tick();
      checkOutput("mdu_pend7", 64'(pend_mask), 64'h80);
      checkOutput("mdu_push_nowrite", 64'(rf_wen), 64'd0);
      idle();
      tick();
      checkWrite("mdu7", 5'd7, 64'hAA);
      checkOutput("mdu_pend_clear", 64'(pend_mask), 64'd0);

      $display("[TB] Starvation");
      applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 64'h99, 1'b0);
      tick();
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b1, 5'(k), 64'h100 + 64'(k), 1'b0, 5'd0, 64'h0, 1'b0);
         checkOutput($sformatf("starve_nostall%0d", k), 64'(wb_stall), 64'd0);
         tick();
         checkWrite($sformatf("starve_wb%0d", k), 5'(k), 64'h100 + 64'(k));
      end
      applyStimulus(1'b1, 5'd5, 64'h105, 1'b0, 5'd0, 64'h0, 1'b0);
      checkOutput("starve_stall", 64'(wb_stall), 64'd1);
      checkOutput("starve_pend9", 64'(pend_mask), 64'h200);
      tick();
      checkWrite("starve_mdu9", 5'd9, 64'h99);
      checkOutput("starve_retry_nostall", 64'(wb_stall), 64'd0);
      tick();
      checkWrite("starve_retry", 5'd5, 64'h105);
      idle();
      tick();

      $display("[TB] Kill queued entry");
      applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 64'hA, 1'b0);
      tick();
      checkOutput("kill_pend3", 64'(pend_mask), 64'h8);
      applyStimulus(1'b1, 5'd3, 64'hB, 1'b0, 5'd0, 64'h0, 1'b0);
      tick();
      checkWrite("kill_wb3", 5'd3, 64'hB);
      checkOutput("kill_pend_clear", 64'(pend_mask), 64'd0);
      idle();
      tick();
      checkOutput("kill_dead_pop", 64'(rf_wen), 64'd0);
      tick();
      checkOutput("kill_after", 64'(rf_wen), 64'd0);

      $display("[TB] Kill same-cycle enqueue");
      applyStimulus(1'b1, 5'd6, 64'hC6, 1'b1, 5'd6, 64'hD6, 1'b0);
      tick();
      checkWrite("kill_enq_wb6", 5'd6, 64'hC6);
      checkOutput("kill_enq_pend", 64'(pend_mask), 64'd0);
      idle();
      tick();
      checkOutput("kill_enq_dead_pop", 64'(rf_wen), 64'd0);
      tick();

      $display("[TB] Register zero");
      applyStimulus(1'b1, 5'd0, 64'h55, 1'b1, 5'd0, 64'h66, 1'b0);
      tick();
      checkOutput("x0_wb_wen", 64'(rf_wen), 64'd0);
      checkOutput("x0_pend", 64'(pend_mask), 64'd0);
      idle();
      tick();
      checkOutput("x0_mdu_wen", 64'(rf_wen), 64'd0);
      tick();
      checkOutput("x0_idle_wen", 64'(rf_wen), 64'd0);

      $display("[TB] Fill and flush");
      applyStimulus(1'b1, 5'd20, 64'h20, 1'b1, 5'd10, 64'h10, 1'b0);
      tick();
      applyStimulus(1'b1, 5'd21, 64'h21, 1'b1, 5'd11, 64'h11, 1'b0);
      checkOutput("fill_ready1", 64'(mdu_ready), 64'd1);
      tick();
      checkWrite("fill_wb21", 5'd21, 64'h21);
      checkOutput("fill_full", 64'(mdu_ready), 64'd0);
      checkOutput("fill_pend", 64'(pend_mask), 64'h0C00);
      applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd12, 64'h12, 1'b1);
      tick();
      checkOutput("flush_ready", 64'(mdu_ready), 64'd1);
      checkOutput("flush_pend", 64'(pend_mask), 64'd0);
      checkOutput("flush_wen", 64'(rf_wen), 64'd0);
      idle();
      tick();
      checkOutput("flush_nostale", 64'(rf_wen), 64'd0);
      applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd13, 64'h13, 1'b0);
      tick();
      applyStimulus(1'b1, 5'd14, 64'hE, 1'b0, 5'd0, 64'h0, 1'b1);
      tick();
      checkWrite("flush_wb14", 5'd14, 64'hE);
      checkOutput("flush2_pend", 64'(pend_mask), 64'd0);
      idle();
      tick();
      checkOutput("flush2_nostale", 64'(rf_wen), 64'd0);

      $display("[TB] Reset mid-write");
      applyStimulus(1'b1, 5'd15, 64'hF, 1'b1, 5'd16, 64'h16, 1'b0);
      tick();
      checkWrite("mid_wb15", 5'd15, 64'hF);
      checkOutput("mid_pend16", 64'(pend_mask), 64'h10000);
      idle();
      #2;
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_wen", 64'(rf_wen), 64'd0);
      checkOutput("mid_rst_wa", 64'(rf_wa), 64'd0);
      checkOutput("mid_rst_pend", 64'(pend_mask), 64'd0);
      checkOutput("mid_rst_ready", 64'(mdu_ready), 64'd1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      tick();
      checkOutput("post_rst_wen", 64'(rf_wen), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
